// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the ID/EX/MEM register-usage fields seen by the hazard controller
//   and the stall/flush controls it returns to the pipeline.
//
//   Signalling: there is no valid/ready handshake on this bundle. Every
//   signal is a level that is meaningful in the cycle it is presented; the
//   controller answers combinationally in the same cycle, and the pipeline
//   latches act on the answer at the next posedge clk.
//
//   Modports:
//     master - pipeline side: drives ID/EX/MEM fields, receives controls
//     slave  - controller side: receives fields, drives controls
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  // ID-stage source operands
  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic       ID_rs1_used;
  logic       ID_rs2_used;
  logic       ID_is_bj;
  // producers still in flight
  logic [4:0] EX_rd;
  logic [4:0] MEM_rd;
  logic       EX_RegWrite;
  logic       MEM_RegWrite;
  // controls back to the pipeline
  logic       PC_EN;
  logic       Data_stall;
  logic       BJ_stall;
  logic       ID_EX_flush;
  logic       flush_active;

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_is_bj,
    output EX_rd, MEM_rd, EX_RegWrite, MEM_RegWrite,
    input  PC_EN, Data_stall, BJ_stall, ID_EX_flush, flush_active
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, ID_is_bj,
    input  EX_rd, MEM_rd, EX_RegWrite, MEM_RegWrite,
    output PC_EN, Data_stall, BJ_stall, ID_EX_flush, flush_active
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard and stall controller for the 5-stage pipeline. Detects RAW
//   dependencies of the ID instruction on producers in EX or MEM (no
//   forwarding, so the consumer waits until the producer reaches WB) and
//   runs a fixed-length IF/ID flush after each taken branch/jump.
//
// Parameters:
//   FLUSH_CYCLES  cycles BJ_stall is held per branch/jump (1..7)
//
// Ports:
//   clk   pipeline clock, all state on posedge
//   rst   synchronous, active-high reset; forces outputs to their idle values
//   hz    pipeline_hazard_ctrl_if.slave
//           in : ID_rs1/2, ID_rs1/2_used, ID_is_bj, EX_rd, MEM_rd,
//                EX_RegWrite, MEM_RegWrite
//           out: PC_EN, Data_stall, BJ_stall, ID_EX_flush,
//                flush_active (debug: FSM is in FLUSH)
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN  adds stall_cnt[31:0] (cycles with Data_stall=1) and
//                       flush_cnt[31:0] (cycles with BJ_stall=1); both clear
//                       on rst and wrap naturally.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // cnt holds the number of FLUSH cycles still to come after the current one
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic rs1_haz, rs2_haz, haz;
  logic pc_en, data_stall, bj_stall, id_ex_flush, flush_active;

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  // A producer in WB is not checked: the register file writes before read.
  assign rs1_haz = hz.ID_rs1_used && (hz.ID_rs1 != 5'd0) &&
                   ((hz.EX_RegWrite  && (hz.EX_rd  == hz.ID_rs1)) ||
                    (hz.MEM_RegWrite && (hz.MEM_rd == hz.ID_rs1)));
  assign rs2_haz = hz.ID_rs2_used && (hz.ID_rs2 != 5'd0) &&
                   ((hz.EX_RegWrite  && (hz.EX_rd  == hz.ID_rs2)) ||
                    (hz.MEM_RegWrite && (hz.MEM_rd == hz.ID_rs2)));
  assign haz     = rs1_haz || rs2_haz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_en        = 1'b1;
    data_stall   = 1'b0;
    bj_stall     = 1'b0;
    id_ex_flush  = 1'b0;
    flush_active = 1'b0;
    if (rst) begin
      // outputs stay at their idle defaults while reset is asserted
      state_nxt = RUN;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        RUN: begin
          data_stall  = haz;
          id_ex_flush = haz;
          pc_en       = !haz;
          // a branch waiting on an operand stalls first; it enters FLUSH
          // in the cycle its hazard clears
          if (hz.ID_is_bj && !haz) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_LOAD;
          end
        end
        FLUSH: begin
          // ID holds the injected NOP, so hazards and ID_is_bj are ignored;
          // the PC loads the resolved target on the last flush cycle
          bj_stall     = 1'b1;
          flush_active = 1'b1;
          pc_en        = (cnt == 3'd0);
          if (cnt == 3'd0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  assign hz.PC_EN        = pc_en;
  assign hz.Data_stall   = data_stall;
  assign hz.BJ_stall     = bj_stall;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.flush_active = flush_active;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, data_stall};
      flush_cnt <= flush_cnt + {31'd0, bj_stall};
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int FC = 3;
  localparam int N_RANDOM = 3000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // output vector layout: {PC_EN, Data_stall, BJ_stall, ID_EX_flush, flush_active}
  function automatic logic [4:0] dut_vec();
    return {hz.PC_EN, hz.Data_stall, hz.BJ_stall, hz.ID_EX_flush, hz.flush_active};
  endfunction

  // ---------------- behavioural model ----------------
  // m_rem = number of flush cycles still owed to the pipeline (0 = running)
  int          m_rem = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  function automatic logic reads_inflight(input logic [4:0] r, input logic used);
    if (!used || r == 5'd0) return 1'b0;
    if (hz.EX_RegWrite && hz.EX_rd == r) return 1'b1;
    if (hz.MEM_RegWrite && hz.MEM_rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_haz();
    return reads_inflight(hz.ID_rs1, hz.ID_rs1_used) ||
           reads_inflight(hz.ID_rs2, hz.ID_rs2_used);
  endfunction

  function automatic logic [4:0] model_out(input int rem);
    logic h;
    if (rst) return 5'b10000;
    if (rem > 0) return {(rem == 1), 1'b0, 1'b1, 1'b0, 1'b1};
    h = model_haz();
    return {!h, h, 1'b0, h, 1'b0};
  endfunction

  always @(posedge clk) begin
    logic [4:0] o;
    o = model_out(m_rem);
    if (rst) begin
      m_rem   = 0;
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      m_stall = m_stall + {31'd0, o[3]};
      m_flush = m_flush + {31'd0, o[2]};
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (hz.ID_is_bj && !model_haz()) m_rem = FC;
    end
  end

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];

  always @(negedge clk) begin
    #1;
    exp_q.push_back(model_out(m_rem));
  end

  always @(negedge clk) begin
    logic [4:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec() !== e) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got %b expected %b", $time, dut_vec(), e);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL perf_cnt t=%0t: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 $time, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    hz.ID_rs1       = 5'd0;
    hz.ID_rs2       = 5'd0;
    hz.ID_rs1_used  = 1'b0;
    hz.ID_rs2_used  = 1'b0;
    hz.ID_is_bj     = 1'b0;
    hz.EX_rd        = 5'd0;
    hz.MEM_rd       = 5'd0;
    hz.EX_RegWrite  = 1'b0;
    hz.MEM_RegWrite = 1'b0;
  endtask

  task automatic random_inputs();
    rst             = ($urandom_range(0, 49) == 0);
    hz.ID_rs1       = 5'($urandom_range(0, 3));
    hz.ID_rs2       = 5'($urandom_range(0, 3));
    hz.ID_rs1_used  = 1'($urandom_range(0, 1));
    hz.ID_rs2_used  = 1'($urandom_range(0, 1));
    hz.ID_is_bj     = ($urandom_range(0, 3) == 0);
    hz.EX_rd        = 5'($urandom_range(0, 3));
    hz.MEM_rd       = 5'($urandom_range(0, 3));
    hz.EX_RegWrite  = 1'($urandom_range(0, 1));
    hz.MEM_RegWrite = 1'($urandom_range(0, 1));
  endtask

  // hand-computed literal expectation for the current cycle
  task automatic chk(input string name, input logic [4:0] e);
    #3;
    checks++;
    if (dut_vec() !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, dut_vec(), e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    hz.ID_rs1 = 5'd5; hz.ID_rs1_used = 1'b1; hz.EX_rd = 5'd5; hz.EX_RegWrite = 1'b1;
    @(negedge clk); chk("reset_c1", 5'b10000);
    @(negedge clk); chk("reset_c2", 5'b10000);

    @(negedge clk); rst = 1'b0; idle_inputs(); chk("idle", 5'b10000);

    // dependency on EX, then the same producer in MEM
    @(negedge clk); hz.ID_rs1 = 5'd5; hz.ID_rs1_used = 1'b1;
    hz.EX_rd = 5'd5; hz.EX_RegWrite = 1'b1; chk("ex_haz", 5'b01010);
    @(negedge clk); hz.EX_RegWrite = 1'b0; hz.EX_rd = 5'd0;
    hz.MEM_rd = 5'd5; hz.MEM_RegWrite = 1'b1; chk("mem_haz", 5'b01010);
    @(negedge clk); hz.MEM_RegWrite = 1'b0; chk("haz_clear", 5'b10000);

    // x0 and unused operand never stall
    @(negedge clk); idle_inputs();
    hz.ID_rs1 = 5'd0; hz.ID_rs1_used = 1'b1; hz.EX_rd = 5'd0; hz.EX_RegWrite = 1'b1;
    hz.ID_rs2 = 5'd7; hz.ID_rs2_used = 1'b0; hz.MEM_rd = 5'd7; hz.MEM_RegWrite = 1'b1;
    chk("x0_unused", 5'b10000);

    // plain branch, with a second ID_is_bj pulse inside FLUSH
    @(negedge clk); idle_inputs(); hz.ID_is_bj = 1'b1; chk("bj_T", 5'b10000);
    @(negedge clk); hz.ID_is_bj = 1'b0; chk("bj_T1", 5'b00101);
    @(negedge clk); hz.ID_is_bj = 1'b1; chk("bj_T2", 5'b00101);
    @(negedge clk); hz.ID_is_bj = 1'b0; chk("bj_T3", 5'b10101);
    @(negedge clk); chk("bj_T4", 5'b10000);

    // branch waiting on a MEM producer
    @(negedge clk); hz.ID_is_bj = 1'b1; hz.ID_rs1 = 5'd9; hz.ID_rs1_used = 1'b1;
    hz.MEM_rd = 5'd9; hz.MEM_RegWrite = 1'b1; chk("bjh_T", 5'b01010);
    @(negedge clk); hz.MEM_RegWrite = 1'b0; chk("bjh_T1", 5'b10000);
    @(negedge clk); idle_inputs(); chk("bjh_T2", 5'b00101);
    @(negedge clk); chk("bjh_T3", 5'b00101);
    @(negedge clk); chk("bjh_T4", 5'b10101);
    @(negedge clk); chk("bjh_T5", 5'b10000);

    // reset in the middle of a flush
    @(negedge clk); hz.ID_is_bj = 1'b1; chk("rstf_T", 5'b10000);
    @(negedge clk); hz.ID_is_bj = 1'b0; chk("rstf_T1", 5'b00101);
    @(negedge clk); rst = 1'b1; chk("rstf_T2", 5'b10000);
    @(negedge clk); rst = 1'b0; chk("rstf_T3", 5'b10000);
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rstf_flush_cnt: got %0d expected 0", flush_cnt);
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < N_RANDOM; i++) begin
      @(negedge clk);
      random_inputs();
    end

    @(negedge clk); rst = 1'b0; idle_inputs();
    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline; it sequences the IF/ID latch, PC and ID/EX latch. Compares ID-stage source registers against EX/MEM destinations and produces `Data_stall` (IF/ID hold, PC hold, ID/EX bubble). Runs a branch/jump flush sequence that drives `BJ_stall` (IF/ID `flush`) for a fixed number of cycles. No forwarding: a consumer waits until the producer has left MEM. Instantiated once in the CPU top, beside `REG_IF_ID`.

## Interface
- `FLUSH_CYCLES`, 3, cycles `BJ_stall` is held per taken branch/jump; legal 1..7
- `clk`  in  1  pipeline clock, all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `ID_rs1`, `ID_rs2`  in  5 each  source register fields of `ID_IR`
- `ID_rs1_used`, `ID_rs2_used`  in  1 each  instruction actually reads rs1/rs2
- `ID_is_bj`  in  1  ID instruction is branch/JAL/JALR
- `EX_rd`, `MEM_rd`  in  5 each  destination register in EX/MEM
- `EX_RegWrite`, `MEM_RegWrite`  in  1 each  EX/MEM instruction writes rd
- `PC_EN`  out  1  PC register enable
- `Data_stall`  out  1  to IF/ID `Data_stall`
- `BJ_stall`  out  1  to IF/ID `flush` (NOP 32'h0000_2003 injected)
- `ID_EX_flush`  out  1  bubble into ID/EX
- `flush_active`  out  1  FSM in FLUSH (debug)

## Operation
- Hazard: `haz = (ID_rs1_used & rs1!=0 & ((EX_RegWrite & EX_rd==rs1) | (MEM_RegWrite & MEM_rd==rs1)))`, same for rs2, ORed. x0 never hazards. WB-stage producer is not a hazard (regfile write-before-read).
- FSM states: RUN, FLUSH. 3-bit down-counter `cnt`.
- RUN: `Data_stall = ID_EX_flush = haz`; `PC_EN = ~haz`; `BJ_stall = 0`.
- RUN, `ID_is_bj & ~haz`: next state FLUSH, `cnt <= FLUSH_CYCLES-1`. Branch with pending hazard stalls first; the FLUSH transition occurs in the cycle the hazard clears.
- FLUSH: `BJ_stall = 1`, `Data_stall = ID_EX_flush = 0` (hazard check suppressed; ID holds NOP), `PC_EN = (cnt==0)` so PC loads the resolved target on the last flush cycle. `cnt` decrements; at `cnt==0` next state RUN.
- Priority: `rst` > data hazard > branch entry. Data stall and `BJ_stall` are never both 1.
- `ID_is_bj` during FLUSH ignored (ID holds NOP).

## Timing
- During and after reset: state RUN, `cnt=0`, `BJ_stall=0`, `flush_active=0`; with zero inputs `PC_EN=1`, `Data_stall=0`, `ID_EX_flush=0`. While `rst=1` outputs are forced to these values regardless of inputs.
- Hazard outputs are combinational from inputs in RUN (0-cycle latency); FSM outputs are registered-state based.
- Load-use / ALU dependency on EX: 2 stall cycles; on MEM: 1 stall cycle.
- Branch at ID in cycle T: FLUSH for cycles T+1..T+FLUSH_CYCLES; `PC_EN=1` in cycle T+FLUSH_CYCLES; RUN at T+FLUSH_CYCLES+1.
- `FLUSH_CYCLES=1`: single FLUSH cycle with `PC_EN=1`.
- `rst` mid-FLUSH: next cycle RUN, `cnt=0`.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `stall_cnt[31:0]` (+1 each cycle `Data_stall=1`) and `flush_cnt[31:0]` (+1 each cycle `BJ_stall=1`); both cleared by `rst`, wrap at 2^32-1 -> 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset: `rst=1` 2 cycles with EX_rd=5, EX_RegWrite=1, rs1=5 used -> `Data_stall=0`, `PC_EN=1`, `BJ_stall=0` throughout.
- EX hazard: rs1=5 used, EX_rd=5 write; next cycle same producer in MEM -> `Data_stall=1`, `PC_EN=0`, `ID_EX_flush=1` for 2 cycles, then 0.
- x0/unused: rs1=0 with EX_rd=0 write; rs2=7 unused with MEM_rd=7 -> no stall.
- Branch: `ID_is_bj=1` at T, FLUSH_CYCLES=3 -> `BJ_stall=1` T+1..T+3, `PC_EN=0,0,1`, RUN at T+4; `ID_is_bj` pulsed at T+2 ignored.
- Branch with hazard: `ID_is_bj=1` and MEM hazard at T -> `Data_stall=1` at T, FLUSH T+2..T+4.
- Reset mid-FLUSH at T+2 -> RUN at T+3, `BJ_stall=0`; with `HAZARD_PERF_CNT_EN`, `flush_cnt` reads 0.
